// File: rtl/fetch_redirect_ctrl_pkg.sv
// rtl/fetch_redirect_ctrl_pkg.sv - shared types and constants for the fetch redirect controller
package fetch_ctrl_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int CNT_W_DEF  = 32;

  // Encoding of the all-zero bubble instruction placed in IF/ID on a flush
  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_ctrl_if_id_reg.sv
// rtl/fetch_redirect_ctrl_if_id_reg.sv - IF/ID pipeline register with load/hold/bubble control
module if_id_reg
  import fetch_ctrl_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              hold_i,
  input  logic              bubble_i,
  input  logic [WORD_W-1:0] pc_i,
  input  logic [WORD_W-1:0] instr_i,
  output logic [WORD_W-1:0] PC,
  output logic [WORD_W-1:0] Instruction,
  output logic              Valid
);

  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] instr_q;
  logic              valid_q;

  // Bubble wins over load; with hold (or nothing) asserted the contents stay put
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (bubble_i) begin
      pc_q    <= '0;
      instr_q <= WORD_W'(NOP_INSTR);
      valid_q <= 1'b0;
    end else if (load_i && !hold_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end

  assign PC          = pc_q;
  assign Instruction = instr_q;
  assign Valid       = valid_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch redirect/stall controller; FETCH_PERF_CNT_EN enables perf counters
module fetch_redirect_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] PC_in,
  input  logic [WORD_W-1:0] Instruction_in,
  input  logic              Hazard,
  input  logic              Branch_Taken_EX,
  input  logic [WORD_W-1:0] Branch_Address_EX,
  output logic              Freeze,
  output logic              Branch_Taken,
  output logic [WORD_W-1:0] Branch_Address,
  output logic [WORD_W-1:0] PC,
  output logic [WORD_W-1:0] Instruction,
  output logic              Valid,
  output logic [CNT_W-1:0]  Stall_Count,
  output logic [CNT_W-1:0]  Flush_Count
);

  fetch_state_e      state_q;
  logic              branch_taken_q;
  logic [WORD_W-1:0] branch_addr_q;

  logic in_run;
  logic take_branch;
  logic load;
  logic hold;
  logic bubble;

  // Branch beats hazard; in REDIRECT both inputs are ignored and IF must not freeze
  assign in_run      = (state_q == RUN);
  assign take_branch = in_run && Branch_Taken_EX;
  assign Freeze      = Hazard && in_run && !Branch_Taken_EX;
  assign load        = in_run && !Hazard && !Branch_Taken_EX;
  assign hold        = Freeze;
  assign bubble      = take_branch || !in_run;

  // Redirect FSM: a taken branch in RUN spends exactly one cycle presenting the target to IF
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= RUN;
      branch_taken_q <= 1'b0;
      branch_addr_q  <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (Branch_Taken_EX) begin
            state_q        <= REDIRECT;
            branch_taken_q <= 1'b1;
            branch_addr_q  <= Branch_Address_EX;
          end else begin
            branch_taken_q <= 1'b0;
          end
        end
        default: begin
          state_q        <= RUN;
          branch_taken_q <= 1'b0;
        end
      endcase
    end
  end

  assign Branch_Taken   = branch_taken_q;
  assign Branch_Address = branch_addr_q;

  if_id_reg #(
    .WORD_W(WORD_W)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .hold_i     (hold),
    .bubble_i   (bubble),
    .pc_i       (PC_in),
    .instr_i    (Instruction_in),
    .PC         (PC),
    .Instruction(Instruction),
    .Valid      (Valid)
  );

`ifdef FETCH_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  // Saturating increments: once all-ones a counter sticks there
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (Freeze && (stall_q != '1)) stall_d = stall_q + CNT_ONE;
    if (bubble && (flush_q != '1)) flush_d = flush_q + CNT_ONE;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign Stall_Count = stall_q;
  assign Flush_Count = flush_q;
`else
  assign Stall_Count = '0;
  assign Flush_Count = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - scoreboard bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [WORD_W-1:0] PC_in;
  logic [WORD_W-1:0] Instruction_in;
  logic              Hazard;
  logic              Branch_Taken_EX;
  logic [WORD_W-1:0] Branch_Address_EX;
  logic              Freeze;
  logic              Branch_Taken;
  logic [WORD_W-1:0] Branch_Address;
  logic [WORD_W-1:0] PC;
  logic [WORD_W-1:0] Instruction;
  logic              Valid;
  logic [CNT_W-1:0]  Stall_Count;
  logic [CNT_W-1:0]  Flush_Count;

  fetch_redirect_ctrl #(
    .WORD_W(WORD_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .PC_in            (PC_in),
    .Instruction_in   (Instruction_in),
    .Hazard           (Hazard),
    .Branch_Taken_EX  (Branch_Taken_EX),
    .Branch_Address_EX(Branch_Address_EX),
    .Freeze           (Freeze),
    .Branch_Taken     (Branch_Taken),
    .Branch_Address   (Branch_Address),
    .PC               (PC),
    .Instruction      (Instruction),
    .Valid            (Valid),
    .Stall_Count      (Stall_Count),
    .Flush_Count      (Flush_Count)
  );

  always #5 clk = ~clk;

  // Freeze is checked during the cycle; everything else after the rising edge
  typedef struct {
    logic        chk_frz;
    logic        frz;
    logic        bt;
    logic        chk_ba;
    logic [31:0] ba;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        vld;
    int          sc;
    int          fc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, req);
    end
  endtask

  task automatic drv(input logic r, input logic h, input logic b, input logic [31:0] ba_ex,
                     input logic [31:0] pcin, input logic [31:0] inin, input exp_t e);
    @(negedge clk);
    rst               = r;
    Hazard            = h;
    Branch_Taken_EX   = b;
    Branch_Address_EX = ba_ex;
    PC_in             = pcin;
    Instruction_in    = inin;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per driven cycle
  initial begin
    exp_t e;
    int   sc_req, fc_req;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk_frz) chk(e.name, "Freeze", {31'b0, Freeze}, {31'b0, e.frz});
        @(posedge clk);
        #1;
`ifdef FETCH_PERF_CNT_EN
        sc_req = e.sc;
        fc_req = e.fc;
`else
        sc_req = 0;
        fc_req = 0;
`endif
        chk(e.name, "Branch_Taken", {31'b0, Branch_Taken}, {31'b0, e.bt});
        if (e.chk_ba) chk(e.name, "Branch_Address", Branch_Address, e.ba);
        chk(e.name, "PC", PC, e.pc);
        chk(e.name, "Instruction", Instruction, e.ins);
        chk(e.name, "Valid", {31'b0, Valid}, {31'b0, e.vld});
        chk(e.name, "Stall_Count", {28'b0, Stall_Count}, sc_req);
        chk(e.name, "Flush_Count", {28'b0, Flush_Count}, fc_req);
      end
    end
  end

  initial begin
    rst = 1'b0; Hazard = 1'b0; Branch_Taken_EX = 1'b0;
    Branch_Address_EX = '0; PC_in = '0; Instruction_in = '0;

    // reset with random inputs
    for (int i = 0; i < 2; i++)
      drv(1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
          '{0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 0, 0, 0, "reset"});
    drv(1, 0, 0, 32'h0, 32'h5, 32'hE3A00001, '{1, 0, 0, 1, 32'h0, 32'h5, 32'hE3A00001, 1, 0, 0, "first_load"});

    // three-cycle stall holds IF/ID
    for (int i = 0; i < 3; i++)
      drv(1, 1, 0, 32'h0, 32'h9, 32'hAAAA, '{1, 1, 0, 0, 32'h0, 32'h5, 32'hE3A00001, 1, i + 1, 0, "stall"});
    drv(1, 0, 0, 32'h0, 32'h8, 32'hE2811001, '{1, 0, 0, 0, 32'h0, 32'h8, 32'hE2811001, 1, 3, 0, "post_stall"});

    // redirect to 0x40
    drv(1, 0, 1, 32'h40, 32'hC, 32'h11, '{1, 0, 1, 1, 32'h40, 32'h0, 32'h0, 0, 3, 1, "redir_t"});
    drv(1, 0, 0, 32'h0, 32'h10, 32'h22, '{1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 3, 2, "redir_t1"});
    drv(1, 0, 0, 32'h0, 32'h40, 32'h33, '{1, 0, 0, 0, 32'h0, 32'h40, 32'h33, 1, 3, 2, "redir_t2"});

    // hazard + branch together, then branch and hazard during REDIRECT ignored
    drv(1, 1, 1, 32'h80, 32'h44, 32'h44, '{1, 0, 1, 1, 32'h80, 32'h0, 32'h0, 0, 3, 3, "simul"});
    drv(1, 1, 1, 32'hC0, 32'h48, 32'h48, '{1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 3, 4, "ign_in_redir"});
    drv(1, 0, 0, 32'h0, 32'h80, 32'h55, '{1, 0, 0, 0, 32'h0, 32'h80, 32'h55, 1, 3, 4, "no_extra1"});
    drv(1, 0, 0, 32'h0, 32'h84, 32'h66, '{1, 0, 0, 0, 32'h0, 32'h84, 32'h66, 1, 3, 4, "no_extra2"});

    // new branch accepted right after REDIRECT
    drv(1, 0, 1, 32'h100, 32'h88, 32'h1, '{1, 0, 1, 1, 32'h100, 32'h0, 32'h0, 0, 3, 5, "b2b_a"});
    drv(1, 0, 0, 32'h0, 32'h8C, 32'h2, '{1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 3, 6, "b2b_redir"});
    drv(1, 0, 1, 32'h200, 32'h90, 32'h3, '{1, 0, 1, 1, 32'h200, 32'h0, 32'h0, 0, 3, 7, "b2b_b"});

    // reset in the REDIRECT cycle drops it
    drv(0, 0, 0, 32'h0, 32'h94, 32'h4, '{1, 0, 0, 1, 32'h0, 32'h0, 32'h0, 0, 0, 0, "mid_reset"});
    drv(1, 0, 0, 32'h0, 32'h300, 32'h77, '{1, 0, 0, 1, 32'h0, 32'h300, 32'h77, 1, 0, 0, "after_reset"});
    drv(1, 1, 0, 32'h0, 32'h304, 32'h78, '{1, 1, 0, 0, 32'h0, 32'h300, 32'h77, 1, 1, 0, "run_stall"});

    // long stall: 4-bit counter saturates at 15
    for (int i = 0; i < 20; i++)
      drv(1, 1, 0, 32'h0, 32'h304, 32'h78,
          '{1, 1, 0, 0, 32'h0, 32'h300, 32'h77, 1, ((i + 2) > 15) ? 15 : (i + 2), 0, "saturate"});
    drv(1, 0, 0, 32'h0, 32'h304, 32'h78, '{1, 0, 0, 0, 32'h0, 32'h304, 32'h78, 1, 15, 0, "sat_hold"});

    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
